// File: rtl/branch_sequencer.sv
// Branch-instruction control sequencer: steps T3..T6 for brzr/brnz/brpl/brmi.
// It drives the datapath strobes, owns the CON flip-flop, and keeps saturating taken/not-taken statistics.
module branch_sequencer #(
  parameter int CNT_W          = 16,
  parameter int SKIP_NOT_TAKEN = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stall,
  input  logic             con_d,
  input  logic             cnt_clr,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlo_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             con,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_con;
  logic [CNT_W-1:0] r_taken;
  logic [CNT_W-1:0] r_ntaken;
  logic             w_retire;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!stall) begin
      case (r_state)
        S_IDLE: if (start) w_next = S_T3;
        S_T3:   w_next = ((SKIP_NOT_TAKEN != 0) && !con_d) ? S_DONE : S_T4;
        S_T4:   w_next = S_T5;
        S_T5:   w_next = S_T6;
        S_T6:   w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Moore decode. pc_in is the only output that also uses the latched CON.
  always_comb begin
    gra     = 1'b0;
    r_out   = 1'b0;
    con_in  = 1'b0;
    pc_out  = 1'b0;
    y_in    = 1'b0;
    c_out   = 1'b0;
    alu_add = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    pc_in   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_T3: begin
        gra    = 1'b1;
        r_out  = 1'b1;
        con_in = 1'b1;
      end
      S_T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      S_T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
      end
      S_T6: begin
        zlo_out = 1'b1;
        pc_in   = r_con;
      end
      S_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // CON is sticky between instructions. It is rewritten only when T3 actually advances.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                              r_con <= 1'b0;
    else if (r_state == S_T3 && !stall)    r_con <= con_d;
  end

  assign w_retire = (r_state == S_DONE) && !stall;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_taken  <= '0;
      r_ntaken <= '0;
    end else if (cnt_clr) begin
      r_taken  <= '0;
      r_ntaken <= '0;
    end else if (w_retire) begin
      if (r_con && (r_taken != {CNT_W{1'b1}}))
        r_taken <= r_taken + CNT_W'(1);
      if (!r_con && (r_ntaken != {CNT_W{1'b1}}))
        r_ntaken <= r_ntaken + CNT_W'(1);
    end
  end

  assign con        = r_con;
  assign taken_cnt  = r_taken;
  assign ntaken_cnt = r_ntaken;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a per-cycle vector table for the default build,
// plus hand sequences for a skip-path, 2-bit-counter build.
module tb_branch_sequencer;

  // Strobe pack {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,zlo_out,pc_in,busy,done}
  localparam logic [11:0] SI  = 12'b000000000000;
  localparam logic [11:0] S3  = 12'b111000000010;
  localparam logic [11:0] S4  = 12'b000110000010;
  localparam logic [11:0] S5  = 12'b000001110010;
  localparam logic [11:0] S6N = 12'b000000001010;
  localparam logic [11:0] S6T = 12'b000000001110;
  localparam logic [11:0] SD  = 12'b000000000011;

  typedef struct {
    logic        clr, start, stall, con_d, cnt_clr;
    logic [11:0] s;
    logic        con;
    logic [15:0] tk, nt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Build A: default parameters.
  logic a_clr = 1'b0, a_start = 1'b0, a_stall = 1'b0, a_con_d = 1'b0, a_cnt_clr = 1'b0;
  logic a_gra, a_r_out, a_con_in, a_pc_out, a_y_in, a_c_out, a_alu_add, a_z_in;
  logic a_zlo_out, a_pc_in, a_busy, a_done, a_con;
  logic [15:0] a_tk, a_nt;

  branch_sequencer #(.CNT_W(16), .SKIP_NOT_TAKEN(0)) u_a (
    .clk(clk), .clr(a_clr), .start(a_start), .stall(a_stall), .con_d(a_con_d),
    .cnt_clr(a_cnt_clr), .gra(a_gra), .r_out(a_r_out), .con_in(a_con_in),
    .pc_out(a_pc_out), .y_in(a_y_in), .c_out(a_c_out), .alu_add(a_alu_add),
    .z_in(a_z_in), .zlo_out(a_zlo_out), .pc_in(a_pc_in), .busy(a_busy),
    .done(a_done), .con(a_con), .taken_cnt(a_tk), .ntaken_cnt(a_nt)
  );

  // Build B: skip-path variant with 2-bit counters.
  logic b_clr = 1'b0, b_start = 1'b0, b_stall = 1'b0, b_con_d = 1'b0, b_cnt_clr = 1'b0;
  logic b_gra, b_r_out, b_con_in, b_pc_out, b_y_in, b_c_out, b_alu_add, b_z_in;
  logic b_zlo_out, b_pc_in, b_busy, b_done, b_con;
  logic [1:0] b_tk, b_nt;

  branch_sequencer #(.CNT_W(2), .SKIP_NOT_TAKEN(1)) u_b (
    .clk(clk), .clr(b_clr), .start(b_start), .stall(b_stall), .con_d(b_con_d),
    .cnt_clr(b_cnt_clr), .gra(b_gra), .r_out(b_r_out), .con_in(b_con_in),
    .pc_out(b_pc_out), .y_in(b_y_in), .c_out(b_c_out), .alu_add(b_alu_add),
    .z_in(b_z_in), .zlo_out(b_zlo_out), .pc_in(b_pc_in), .busy(b_busy),
    .done(b_done), .con(b_con), .taken_cnt(b_tk), .ntaken_cnt(b_nt)
  );

  wire [11:0] a_s = {a_gra, a_r_out, a_con_in, a_pc_out, a_y_in, a_c_out, a_alu_add,
                     a_z_in, a_zlo_out, a_pc_in, a_busy, a_done};
  wire [11:0] b_s = {b_gra, b_r_out, b_con_in, b_pc_out, b_y_in, b_c_out, b_alu_add,
                     b_z_in, b_zlo_out, b_pc_in, b_busy, b_done};

  task automatic v(input logic clr, start, stall, con_d, cnt_clr,
                   input logic [11:0] s, input logic con, input int tk, nt);
    vec_t r;
    r.clr = clr; r.start = start; r.stall = stall; r.con_d = con_d; r.cnt_clr = cnt_clr;
    r.s = s; r.con = con; r.tk = 16'(tk); r.nt = 16'(nt);
    vecs.push_back(r);
  endtask

  // One cycle on build B: drive at the falling edge, check the state seen in this cycle.
  task automatic b_cyc(input string name, input logic start, con_d, stall, cnt_clr,
                       input logic [11:0] es, input logic econ, input int etk, ent);
    @(negedge clk);
    b_start = start; b_con_d = con_d; b_stall = stall; b_cnt_clr = cnt_clr;
    #1;
    n_vec++;
    if ({b_s, b_con, b_tk, b_nt} !== {es, econ, 2'(etk), 2'(ent)}) begin
      n_err++;
      $display("FAIL B/%s: got s=%b con=%b tk=%0d nt=%0d, want s=%b con=%b tk=%0d nt=%0d",
               name, b_s, b_con, b_tk, b_nt, es, econ, etk, ent);
    end
  endtask

  initial begin
    //  clr st stl cd cc  strobes con tk nt
    v(0, 0, 0, 0, 0, SI,  0, 0, 0);   // 0 reset held
    v(0, 1, 0, 1, 0, SI,  0, 0, 0);
    v(0, 0, 0, 0, 0, SI,  0, 0, 0);
    v(1, 0, 0, 0, 0, SI,  0, 0, 0);   // 3 first cycle after release
    v(1, 1, 0, 0, 0, SI,  0, 0, 0);   // 4 taken branch start
    v(1, 0, 0, 1, 0, S3,  0, 0, 0);
    v(1, 0, 0, 0, 0, S4,  1, 0, 0);
    v(1, 0, 0, 0, 0, S5,  1, 0, 0);
    v(1, 0, 0, 0, 0, S6T, 1, 0, 0);
    v(1, 0, 0, 0, 0, SD,  1, 0, 0);
    v(1, 0, 0, 0, 0, SI,  1, 1, 0);   // 10
    v(1, 1, 0, 1, 0, SI,  1, 1, 0);   // 11 not-taken, con_d toggles after T3
    v(1, 0, 0, 0, 0, S3,  1, 1, 0);
    v(1, 0, 0, 1, 0, S4,  0, 1, 0);
    v(1, 0, 0, 1, 0, S5,  0, 1, 0);
    v(1, 0, 0, 1, 0, S6N, 0, 1, 0);
    v(1, 0, 0, 1, 0, SD,  0, 1, 0);
    v(1, 0, 0, 0, 0, SI,  0, 1, 1);   // 17
    v(1, 1, 0, 1, 0, SI,  0, 1, 1);   // 18 stall 3 cycles in T5
    v(1, 0, 0, 1, 0, S3,  0, 1, 1);
    v(1, 0, 0, 0, 0, S4,  1, 1, 1);
    v(1, 0, 1, 0, 0, S5,  1, 1, 1);
    v(1, 0, 1, 1, 0, S5,  1, 1, 1);
    v(1, 0, 1, 0, 0, S5,  1, 1, 1);
    v(1, 0, 0, 0, 0, S5,  1, 1, 1);
    v(1, 0, 0, 0, 0, S6T, 1, 1, 1);
    v(1, 0, 0, 0, 0, SD,  1, 1, 1);   // 26 done three cycles late
    v(1, 0, 0, 0, 0, SI,  1, 2, 1);
    v(1, 1, 1, 0, 0, SI,  1, 2, 1);   // 28 start under stall is dropped
    v(1, 0, 0, 0, 0, SI,  1, 2, 1);
    v(1, 1, 0, 0, 0, SI,  1, 2, 1);   // 30 start during T4 and DONE ignored
    v(1, 0, 0, 0, 0, S3,  1, 2, 1);
    v(1, 1, 0, 1, 0, S4,  0, 2, 1);
    v(1, 0, 0, 1, 0, S5,  0, 2, 1);
    v(1, 0, 0, 1, 0, S6N, 0, 2, 1);
    v(1, 1, 0, 0, 0, SD,  0, 2, 1);
    v(1, 0, 0, 0, 0, SI,  0, 2, 2);
    v(1, 0, 0, 0, 0, SI,  0, 2, 2);   // 37
    v(1, 1, 0, 1, 0, SI,  0, 2, 2);   // 38 abort mid-T4
    v(1, 0, 0, 1, 0, S3,  0, 2, 2);
    v(1, 0, 0, 0, 0, S4,  1, 2, 2);
    v(0, 0, 0, 0, 0, SI,  0, 0, 0);
    v(1, 0, 0, 0, 0, SI,  0, 0, 0);
    v(1, 0, 0, 0, 0, SI,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_clr = vecs[i].clr; a_start = vecs[i].start; a_stall = vecs[i].stall;
      a_con_d = vecs[i].con_d; a_cnt_clr = vecs[i].cnt_clr;
      #1;
      n_vec++;
      if ({a_s, a_con, a_tk, a_nt} !== {vecs[i].s, vecs[i].con, vecs[i].tk, vecs[i].nt}) begin
        n_err++;
        $display("FAIL A/row%0d: got s=%b con=%b tk=%0d nt=%0d, want s=%b con=%b tk=%0d nt=%0d",
                 i, a_s, a_con, a_tk, a_nt, vecs[i].s, vecs[i].con, vecs[i].tk, vecs[i].nt);
      end
    end

    // Build B: release reset, then a not-taken branch on the skip path.
    @(negedge clk); b_clr = 1'b1;
    b_cyc("rst",      0, 0, 0, 0, SI, 0, 0, 0);
    b_cyc("nt_start", 1, 0, 0, 0, SI, 0, 0, 0);
    b_cyc("nt_t3",    0, 0, 0, 0, S3, 0, 0, 0);
    b_cyc("nt_done",  0, 1, 0, 0, SD, 0, 0, 0);
    b_cyc("nt_idle",  0, 1, 0, 0, SI, 0, 0, 1);

    // Five taken branches: the 2-bit counter sticks at 3.
    for (int k = 0; k < 5; k++) begin
      b_cyc("sat_start", 1, 1, 0, 0, SI,  (k != 0), (k > 3) ? 3 : k, 1);
      b_cyc("sat_t3",    0, 1, 0, 0, S3,  (k != 0), (k > 3) ? 3 : k, 1);
      b_cyc("sat_t4",    0, 0, 0, 0, S4,  1,        (k > 3) ? 3 : k, 1);
      b_cyc("sat_t5",    0, 0, 0, 0, S5,  1,        (k > 3) ? 3 : k, 1);
      b_cyc("sat_t6",    0, 0, 0, 0, S6T, 1,        (k > 3) ? 3 : k, 1);
      b_cyc("sat_done",  0, 0, 0, 0, SD,  1,        (k > 3) ? 3 : k, 1);
    end
    b_cyc("sat_idle", 0, 0, 0, 0, SI, 1, 3, 1);

    // cnt_clr in the same cycle as a DONE exit wins over the increment.
    b_cyc("clr_start", 1, 1, 0, 0, SI,  1, 3, 1);
    b_cyc("clr_t3",    0, 1, 0, 0, S3,  1, 3, 1);
    b_cyc("clr_t4",    0, 0, 0, 0, S4,  1, 3, 1);
    b_cyc("clr_t5",    0, 0, 0, 0, S5,  1, 3, 1);
    b_cyc("clr_t6",    0, 0, 0, 0, S6T, 1, 3, 1);
    b_cyc("clr_done",  0, 0, 0, 1, SD,  1, 3, 1);
    b_cyc("clr_idle",  0, 0, 0, 0, SI,  1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
